// File: rtl/eth_gmii_pkg.sv
// Shared GMII/Ethernet constants, the frame-source state encoding and a
// helper that picks one transmitted FCS byte out of the running CRC.
package eth_gmii_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DROP,
        ST_IFG
    } gmii_src_state_t;

    // FCS is the complemented CRC, sent least-significant byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
        logic [31:0] w_inv;
        w_inv = ~crc;
        return w_inv[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gmii_phy_rx_source_if.sv
// Payload AXI-stream plus the GMII receive-side bus toward the MAC.
// The frame source is the slave of the stream and drives the GMII signals.
interface gmii_phy_rx_source_if;

    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready, gmii_rxd, gmii_rx_dv, gmii_rx_er
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready, gmii_rxd, gmii_rx_dv, gmii_rx_er
    );

endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
module eth_crc32_byte
    import eth_gmii_pkg::*;
(
    input  logic [31:0] i_crc_in,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_out
);

    logic [31:0] w_crc;

    // Shift the byte through the register one bit at a time, LSB first.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each loop step sees the previous one; clocked state uses '<='.
        w_crc = i_crc_in ^ {24'd0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ ETH_CRC_POLY) : (w_crc >> 1);
        end
        o_crc_out = w_crc;
    end

endmodule

// File: rtl/gmii_phy_rx_source.sv
// PHY-side GMII frame source: wraps an AXI-stream payload in preamble/SFD,
// optional zero padding and FCS, then holds the link idle for the IFG.
module gmii_phy_rx_source
    import eth_gmii_pkg::*;
#(
    parameter bit ENABLE_FCS       = 1'b1,
    parameter bit ENABLE_PADDING   = 1'b1,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int PREAMBLE_LEN     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gmii_phy_rx_source_if.slave    bus,
    input  logic [7:0]             ifg_delay,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   underflow
);

    localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - 4);
    localparam logic [3:0]  PRE_LEN    = 4'(PREAMBLE_LEN);

    gmii_src_state_t r_state;
    gmii_src_state_t w_state_next;

    logic [15:0] r_byte_cnt;
    logic [3:0]  r_pre_cnt;
    logic [7:0]  r_ifg_cnt;
    logic [1:0]  r_fcs_idx;
    logic [31:0] r_crc;
    logic [7:0]  r_rxd;
    logic        r_dv;
    logic        r_er;
    logic        r_frame_done;
    logic        r_underflow;

    logic [15:0] w_byte_cnt_inc;
    logic [31:0] w_crc_next;
    logic [7:0]  w_crc_data;
    logic        w_crc_en;
    logic [7:0]  w_rxd;
    logic        w_dv;
    logic        w_er;
    logic        w_done;
    logic        w_unf;
    logic        w_tready;

    assign w_byte_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;

    eth_crc32_byte u_crc (
        .i_crc_in  (r_crc),
        .i_data    (w_crc_data),
        .o_crc_out (w_crc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (bus.s_axis_tvalid) w_state_next = ST_PREAMBLE;
            ST_PREAMBLE: if (r_pre_cnt == PRE_LEN) w_state_next = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (!bus.s_axis_tvalid) begin
                    w_state_next = ST_DROP;
                end else if (bus.s_axis_tlast) begin
                    if (ENABLE_PADDING && (w_byte_cnt_inc < PAD_TARGET)) w_state_next = ST_PAD;
                    else if (ENABLE_FCS)                                  w_state_next = ST_FCS;
                    else                                                  w_state_next = ST_IFG;
                end
            end
            ST_PAD:      if (w_byte_cnt_inc >= PAD_TARGET) w_state_next = ENABLE_FCS ? ST_FCS : ST_IFG;
            ST_FCS:      if (r_fcs_idx == 2'd3) w_state_next = ST_IFG;
            ST_DROP:     if (bus.s_axis_tvalid && bus.s_axis_tlast) w_state_next = ST_IFG;
            ST_IFG:      if (r_ifg_cnt <= 8'd1) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Output decode: values loaded into the GMII registers at the next edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        w_rxd      = 8'h00;
        w_dv       = 1'b0;
        w_er       = 1'b0;
        w_done     = 1'b0;
        w_unf      = 1'b0;
        w_tready   = 1'b0;
        w_crc_en   = 1'b0;
        w_crc_data = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (bus.s_axis_tvalid) begin
                    w_rxd = ETH_PREAMBLE;
                    w_dv  = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                w_rxd = (r_pre_cnt == PRE_LEN) ? ETH_SFD : ETH_PREAMBLE;
                w_dv  = 1'b1;
            end
            ST_PAYLOAD: begin
                w_tready = 1'b1;
                w_dv     = 1'b1;
                if (bus.s_axis_tvalid) begin
                    w_rxd      = bus.s_axis_tdata;
                    w_er       = bus.s_axis_tuser;
                    w_crc_en   = 1'b1;
                    w_crc_data = bus.s_axis_tdata;
                    w_done     = bus.s_axis_tlast && (w_state_next == ST_IFG);
                end else begin
                    w_er  = 1'b1;
                    w_unf = 1'b1;
                end
            end
            ST_PAD: begin
                w_dv     = 1'b1;
                w_crc_en = 1'b1;
                w_done   = (w_state_next == ST_IFG);
            end
            ST_FCS: begin
                w_rxd  = fcs_byte(r_crc, r_fcs_idx);
                w_dv   = 1'b1;
                w_done = (r_fcs_idx == 2'd3);
            end
            ST_DROP: w_tready = 1'b1;
            default: ;
        endcase
    end

    // Counters, CRC accumulator and registered GMII outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: only control and output registers need reset; r_crc is reset too because it has no IDLE-independent reload path worth trusting after a mid-frame abort.
            r_rxd        <= 8'h00;
            r_dv         <= 1'b0;
            r_er         <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
            r_byte_cnt   <= 16'd0;
            r_pre_cnt    <= 4'd0;
            r_ifg_cnt    <= 8'd0;
            r_fcs_idx    <= 2'd0;
            r_crc        <= ETH_CRC_INIT;
        end else begin
            r_rxd        <= w_rxd;
            r_dv         <= w_dv;
            r_er         <= w_er;
            r_frame_done <= w_done;
            r_underflow  <= w_unf;
            if (r_state == ST_IDLE) begin
                r_pre_cnt  <= 4'd1;
                r_byte_cnt <= 16'd0;
                r_fcs_idx  <= 2'd0;
                r_crc      <= ETH_CRC_INIT;
            end
            if ((r_state == ST_PREAMBLE) && (r_pre_cnt != PRE_LEN)) r_pre_cnt <= r_pre_cnt + 4'd1;
            if (w_crc_en) begin
                r_crc      <= w_crc_next;
                r_byte_cnt <= w_byte_cnt_inc;
            end
            if (r_state == ST_FCS) r_fcs_idx <= r_fcs_idx + 2'd1;
            if ((w_state_next == ST_IFG) && (r_state != ST_IFG))
                r_ifg_cnt <= (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
            else if (r_state == ST_IFG)
                r_ifg_cnt <= r_ifg_cnt - 8'd1;
        end
    end

    assign bus.s_axis_tready = w_tready;
    assign bus.gmii_rxd      = r_rxd;
    assign bus.gmii_rx_dv    = r_dv;
    assign bus.gmii_rx_er    = r_er;
    assign busy              = (r_state != ST_IDLE);
    assign frame_done        = r_frame_done;
    assign underflow         = r_underflow;

endmodule

// File: tb/tb_gmii_phy_rx_source.sv
// Bench for gmii_phy_rx_source: random and directed frames with a queue-based
// scoreboard fed from a frame-level reference model (CRC via lookup table).
module tb_gmii_phy_rx_source;
    import eth_gmii_pkg::*;

    localparam int MIN_LEN = 64;
    localparam int PRE_LEN = 7;

    typedef struct packed {
        logic [7:0] d;
        logic       er;
        logic       done;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    gmii_phy_rx_source_if bus ();
    gmii_phy_rx_source_if bus_np ();
    logic [7:0] ifg_delay;
    logic       busy, frame_done, underflow;
    logic       busy_np, frame_done_np, underflow_np;

    gmii_phy_rx_source dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ifg_delay(ifg_delay),
        .busy(busy), .frame_done(frame_done), .underflow(underflow)
    );

    gmii_phy_rx_source #(.ENABLE_PADDING(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .bus(bus_np), .ifg_delay(8'd3),
        .busy(busy_np), .frame_done(frame_done_np), .underflow(underflow_np)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    exp_t np_q[$];
    int   gap_q[$];
    logic mon_en = 1'b0;
    int   np_dv_cnt = 0;
    logic [31:0] crc_tab [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic abort_run(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "run aborted");
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic er, input logic done, input logic unf);
        exp_t e;
        e.d = d; e.er = er; e.done = done; e.unf = unf;
        return e;
    endfunction

    // Reference FCS: table-driven CRC-32 over the whole byte sequence.
    function automatic logic [31:0] model_fcs(input logic [7:0] data [$]);
        logic [31:0] c;
        logic [7:0]  idx;
        c = 32'hFFFFFFFF;
        foreach (data[i]) begin
            idx = c[7:0] ^ data[i];
            c = (c >> 8) ^ crc_tab[idx];
        end
        return ~c;
    endfunction

    // Expected GMII byte stream for one frame.
    task automatic queue_frame(input logic [7:0] pl [$], input logic us [$], input int unf_at);
        logic [7:0]  fr [$];
        logic [31:0] fcs;
        for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hD5, 1'b0, 1'b0, 1'b0));
        if (unf_at >= 0) begin
            for (int i = 0; i < unf_at; i++) exp_q.push_back(mk(pl[i], us[i], 1'b0, 1'b0));
            exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1));
        end else begin
            fr = pl;
            while (fr.size() < MIN_LEN - 4) fr.push_back(8'h00);
            foreach (fr[i]) exp_q.push_back(mk(fr[i], (i < pl.size()) ? us[i] : 1'b0, 1'b0, 1'b0));
            fcs = model_fcs(fr);
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(fcs[8*k +: 8], 1'b0, k == 3, 1'b0));
        end
    endtask

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (bus.s_axis_tready) break;
            if (++t > 1000) abort_run("accept_timeout");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] pl [$], input logic us [$], input int unf_at, input int gap_exp);
        gap_q.push_back(gap_exp);
        queue_frame(pl, us, unf_at);
        for (int i = 0; i < pl.size(); i++) begin
            if (i == unf_at) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.s_axis_tdata  = pl[i];
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (i == pl.size() - 1);
            bus.s_axis_tuser  = us[i];
            wait_accept();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            if (++t > 3000) abort_run("drain_timeout");
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the default-configuration source.
    initial begin : monitor
        exp_t e;
        int   g;
        int   gap_cnt = 0;
        logic prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_dv = 1'b0;
                gap_cnt = 0;
            end else if (bus.gmii_rx_dv) begin
                if (!prev_dv && gap_q.size() > 0) begin
                    g = gap_q.pop_front();
                    if (g >= 0) check("ifg_gap", gap_cnt, g);
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: rxd=%0h er=%0b with nothing expected", bus.gmii_rxd, bus.gmii_rx_er);
                end else begin
                    e = exp_q.pop_front();
                    check("rxd", bus.gmii_rxd, e.d);
                    check("rx_er", bus.gmii_rx_er, e.er);
                    check("frame_done", frame_done, e.done);
                    check("underflow", underflow, e.unf);
                    check("busy", busy, 1);
                end
                prev_dv = 1'b1;
                gap_cnt = 0;
            end else begin
                check("idle_quiet", {bus.gmii_rxd, bus.gmii_rx_er, frame_done, underflow}, 0);
                prev_dv = 1'b0;
                gap_cnt++;
            end
        end
    end

    // Scoreboard monitor for the no-padding source.
    initial begin : monitor_np
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && bus_np.gmii_rx_dv) begin
                np_dv_cnt++;
                if (np_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL np_unexpected_byte: rxd=%0h with nothing expected", bus_np.gmii_rxd);
                end else begin
                    e = np_q.pop_front();
                    check("np_rxd", bus_np.gmii_rxd, e.d);
                    check("np_frame_done", frame_done_np, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] pl [$];
        logic       us [$];
        logic [7:0] np_msg [$];
        logic [31:0] c;
        int len, unf_at, gap;
        logic b2b, prev_unf;
        int t;

        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        bus.s_axis_tdata = 8'h00; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
        bus_np.s_axis_tdata = 8'h00; bus_np.s_axis_tvalid = 1'b0; bus_np.s_axis_tlast = 1'b0; bus_np.s_axis_tuser = 1'b0;
        ifg_delay = 8'd12;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rxd", bus.gmii_rxd, 0);
        check("rst_dv", bus.gmii_rx_dv, 0);
        check("rst_er", bus.gmii_rx_er, 0);
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_done, underflow}, 0);
        check("rst_np_dv", bus_np.gmii_rx_dv, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // No padding: "123456789" with the well-known FCS bytes.
        for (int i = 0; i < PRE_LEN; i++) np_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        np_q.push_back(mk(8'hD5, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 9; i++) begin
            np_msg.push_back(8'(8'h31 + i));
            np_q.push_back(mk(8'(8'h31 + i), 1'b0, 1'b0, 1'b0));
        end
        np_q.push_back(mk(8'h26, 1'b0, 1'b0, 1'b0));
        np_q.push_back(mk(8'h39, 1'b0, 1'b0, 1'b0));
        np_q.push_back(mk(8'hF4, 1'b0, 1'b0, 1'b0));
        np_q.push_back(mk(8'hCB, 1'b0, 1'b1, 1'b0));
        foreach (np_msg[i]) begin
            bus_np.s_axis_tdata  = np_msg[i];
            bus_np.s_axis_tvalid = 1'b1;
            bus_np.s_axis_tlast  = (i == 8);
            t = 0;
            forever begin
                @(negedge clk);
                if (bus_np.s_axis_tready) break;
                if (++t > 1000) abort_run("np_accept_timeout");
            end
            @(posedge clk);
            #1;
        end
        bus_np.s_axis_tvalid = 1'b0;
        bus_np.s_axis_tlast  = 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            if (np_q.size() == 0 && !busy_np) break;
            if (++t > 1000) abort_run("np_drain_timeout");
        end
        check("np_dv_cycles", np_dv_cnt, 21);
        @(posedge clk);
        #1;

        // Short frame padded to minimum length.
        pl.delete(); us.delete();
        for (int i = 0; i < 10; i++) begin pl.push_back(8'(i)); us.push_back(1'b0); end
        send_frame(pl, us, -1, -1);
        drain();

        // Underflow after the 5th payload byte.
        pl.delete(); us.delete();
        for (int i = 0; i < 12; i++) begin pl.push_back(8'($urandom)); us.push_back(1'b0); end
        send_frame(pl, us, 5, -1);
        drain();

        // Error injection on byte 3 of a 64-byte frame.
        pl.delete(); us.delete();
        for (int i = 0; i < 64; i++) begin pl.push_back(8'($urandom)); us.push_back(i == 3); end
        send_frame(pl, us, -1, -1);
        drain();

        // Back-to-back with ifg_delay=12, then with ifg_delay=0.
        for (int pass = 0; pass < 2; pass++) begin
            ifg_delay = (pass == 0) ? 8'd12 : 8'd0;
            for (int f = 0; f < 2; f++) begin
                pl.delete(); us.delete();
                len = (f == 0) ? 20 : 70;
                for (int i = 0; i < len; i++) begin pl.push_back(8'($urandom)); us.push_back(1'b0); end
                send_frame(pl, us, -1, (f == 0) ? -1 : ((pass == 0) ? 12 : 1));
            end
            drain();
        end

        // Randomised frames.
        prev_unf = 1'b0;
        for (int f = 0; f < 25; f++) begin
            b2b = (f > 0) && ($urandom_range(0, 1) == 1);
            if (!b2b) begin
                drain();
                ifg_delay = 8'($urandom_range(0, 15));
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
            len = $urandom_range(2, 80);
            pl.delete(); us.delete();
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                us.push_back($urandom_range(0, 9) == 0);
            end
            unf_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            gap = (b2b && !prev_unf) ? ((ifg_delay == 8'd0) ? 1 : int'(ifg_delay)) : -1;
            send_frame(pl, us, unf_at, gap);
            prev_unf = (unf_at >= 0);
        end
        drain();

        // Reset in the middle of the payload.
        mon_en = 1'b0;
        gap_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus.s_axis_tdata  = 8'(8'hA0 + i);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = 1'b0;
            wait_accept();
        end
        rst_n = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_dv", bus.gmii_rx_dv, 0);
        check("midrst_er", bus.gmii_rx_er, 0);
        check("midrst_tready", bus.s_axis_tready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {frame_done, underflow}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_pulses", {frame_done, underflow, bus.gmii_rx_dv}, 0);
        exp_q.delete();
        mon_en = 1'b1;
        pl.delete(); us.delete();
        for (int i = 0; i < 30; i++) begin pl.push_back(8'($urandom)); us.push_back(1'b0); end
        send_frame(pl, us, -1, -1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
